// File: rtl/hermes_dma.sv
// hermes_dma: independent SEND and RECEIVE DMA engines between PE memory and a Hermes
// router port. Each engine walks up to two word-aligned segments and shares one memory port.

module hermes_dma_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   data_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   buf_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop, do_push;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) buf_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign data_o  = buf_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module hermes_dma #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        operation_i,
  input  logic [31:0] size_i,
  input  logic [31:0] size_2_i,
  input  logic [31:0] address_i,
  input  logic [31:0] address_2_i,
  output logic        send_active_o,
  output logic        receive_active_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        tx_o,
  output logic [31:0] data_o,
  input  logic        credit_i,
  input  logic        rx_i,
  input  logic [31:0] data_i,
  output logic        credit_o
);
  localparam int          CW        = $clog2(BUF_DEPTH) + 1;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic { OP_SEND = 1'b0, OP_RECEIVE = 1'b1 } hermes_op_t;
  typedef enum logic [1:0] { IDLE, SEG1, SEG2, DRAIN } eng_state_e;

  // SEND engine state
  eng_state_e    s_state_q, s_state_d;
  logic [31:0]   s_addr_q, s_addr_d, s_rem_q, s_rem_d;
  logic [31:0]   s_addr2_q, s_addr2_d, s_size2_q, s_size2_d;
  logic          s_inflight_q;
  logic [CW-1:0] s_count, s_level, s_count_next;
  logic [31:0]   s_head;
  logic          s_seg, s_rd, s_pop;

  // RECEIVE engine state
  eng_state_e    r_state_q, r_state_d;
  logic [31:0]   r_addr_q, r_addr_d, r_rem_q, r_rem_d;
  logic [31:0]   r_addr2_q, r_addr2_d, r_size2_q, r_size2_d;
  logic [32:0]   r_left_q, r_left_d;
  logic [CW-1:0] r_count;
  logic [31:0]   r_head;
  logic          r_wr, r_push;

  hermes_dma_fifo #(.DEPTH(BUF_DEPTH), .CW(CW)) u_send_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (s_inflight_q),
    .data_i (mem_data_i),
    .pop_i  (s_pop),
    .data_o (s_head),
    .count_o(s_count)
  );

  hermes_dma_fifo #(.DEPTH(BUF_DEPTH), .CW(CW)) u_recv_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (r_push),
    .data_i (data_i),
    .pop_i  (r_wr),
    .data_o (r_head),
    .count_o(r_count)
  );

  // Memory port: a pending RECEIVE write always beats a SEND read.
  assign r_wr         = ((r_state_q == SEG1) || (r_state_q == SEG2)) && (r_count != '0);
  assign s_seg        = (s_state_q == SEG1) || (s_state_q == SEG2);
  assign s_level      = s_count + CW'(s_inflight_q);
  assign s_rd         = s_seg && (s_level < CW'(BUF_DEPTH)) && !r_wr;
  assign s_pop        = tx_o && credit_i;
  assign s_count_next = s_count + CW'(s_inflight_q) - CW'(s_pop);

  assign credit_o = (r_state_q != IDLE) && (r_count != CW'(BUF_DEPTH)) && (r_left_q != '0);
  assign r_push   = rx_i && credit_o;

  assign send_active_o    = (s_state_q != IDLE);
  assign receive_active_o = (r_state_q != IDLE);
  assign tx_o             = (s_count != '0);
  assign data_o           = tx_o ? s_head : 32'h0;
  assign mem_en_o         = r_wr || s_rd;
  assign mem_we_o         = r_wr ? 4'hF : 4'h0;
  assign mem_addr_o       = r_wr ? r_addr_q : (s_rd ? s_addr_q : 32'h0);
  assign mem_data_o       = r_wr ? r_head : 32'h0;

  always_comb begin
    s_state_d = s_state_q;
    s_addr_d  = s_addr_q;
    s_rem_d   = s_rem_q;
    s_addr2_d = s_addr2_q;
    s_size2_d = s_size2_q;
    case (s_state_q)
      IDLE: begin
        if (start_i && (operation_i == OP_SEND)) begin
          s_addr2_d = address_2_i & ADDR_MASK;
          s_size2_d = size_2_i;
          if (size_i != '0) begin
            s_state_d = SEG1;
            s_addr_d  = address_i & ADDR_MASK;
            s_rem_d   = size_i;
          end else if (size_2_i != '0) begin
            s_state_d = SEG2;
            s_addr_d  = address_2_i & ADDR_MASK;
            s_rem_d   = size_2_i;
          end else begin
            s_state_d = DRAIN;
          end
        end
      end
      SEG1, SEG2: begin
        if (s_rd) begin
          s_addr_d = s_addr_q + 32'd4;
          s_rem_d  = s_rem_q - 32'd1;
          if (s_rem_q == 32'd1) begin
            if ((s_state_q == SEG1) && (s_size2_q != '0)) begin
              s_state_d = SEG2;
              s_addr_d  = s_addr2_q;
              s_rem_d   = s_size2_q;
            end else begin
              s_state_d = DRAIN;
            end
          end
        end
      end
      default: begin
        // Leave as the final flit is handed over so busy drops the next cycle.
        if ((s_count_next == '0) && !s_inflight_q) s_state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_rem_d   = r_rem_q;
    r_addr2_d = r_addr2_q;
    r_size2_d = r_size2_q;
    r_left_d  = r_left_q - 33'(r_push);
    case (r_state_q)
      IDLE: begin
        if (start_i && (operation_i == OP_RECEIVE)) begin
          r_addr2_d = address_2_i & ADDR_MASK;
          r_size2_d = size_2_i;
          r_left_d  = {1'b0, size_i} + {1'b0, size_2_i};
          if (size_i != '0) begin
            r_state_d = SEG1;
            r_addr_d  = address_i & ADDR_MASK;
            r_rem_d   = size_i;
          end else if (size_2_i != '0) begin
            r_state_d = SEG2;
            r_addr_d  = address_2_i & ADDR_MASK;
            r_rem_d   = size_2_i;
          end else begin
            r_state_d = DRAIN;
          end
        end
      end
      SEG1, SEG2: begin
        if (r_wr) begin
          r_addr_d = r_addr_q + 32'd4;
          r_rem_d  = r_rem_q - 32'd1;
          if (r_rem_q == 32'd1) begin
            if ((r_state_q == SEG1) && (r_size2_q != '0)) begin
              r_state_d = SEG2;
              r_addr_d  = r_addr2_q;
              r_rem_d   = r_size2_q;
            end else begin
              r_state_d = IDLE;
            end
          end
        end
      end
      default: r_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_state_q    <= IDLE;
      s_addr_q     <= '0;
      s_rem_q      <= '0;
      s_addr2_q    <= '0;
      s_size2_q    <= '0;
      s_inflight_q <= 1'b0;
      r_state_q    <= IDLE;
      r_addr_q     <= '0;
      r_rem_q      <= '0;
      r_addr2_q    <= '0;
      r_size2_q    <= '0;
      r_left_q     <= '0;
    end else begin
      s_state_q    <= s_state_d;
      s_addr_q     <= s_addr_d;
      s_rem_q      <= s_rem_d;
      s_addr2_q    <= s_addr2_d;
      s_size2_q    <= s_size2_d;
      s_inflight_q <= s_rd;
      r_state_q    <= r_state_d;
      r_addr_q     <= r_addr_d;
      r_rem_q      <= r_rem_d;
      r_addr2_q    <= r_addr2_d;
      r_size2_q    <= r_size2_d;
      r_left_q     <= r_left_d;
    end
  end
endmodule

// File: tb/tb_hermes_dma.sv
// Self-checking bench for hermes_dma: cycle loop drives router/memory sides and records
// every memory access and flit, then each test compares against addresses/data it derives.

module tb_hermes_dma;
  localparam int DEPTH = 2;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        start_i = 1'b0, operation_i = 1'b0;
  logic [31:0] size_i = '0, size_2_i = '0, address_i = '0, address_2_i = '0;
  logic        send_active_o, receive_active_o, mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, data_o;
  logic [31:0] mem_data_i = '0, data_i = '0;
  logic        tx_o, credit_i = 1'b0, rx_i = 1'b0, credit_o;

  hermes_dma #(.BUF_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .operation_i(operation_i),
    .size_i(size_i), .size_2_i(size_2_i), .address_i(address_i), .address_2_i(address_2_i),
    .send_active_o(send_active_o), .receive_active_o(receive_active_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i),
    .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    bit          op;
    logic [31:0] s1, a1, s2, a2;
  } start_t;

  start_t      starts[$];
  logic [31:0] rd_addr_q[$], flit_q[$], wr_addr_q[$], wr_data_q[$], rx_src_q[$];
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic [31:0] mem_key;
  int errors = 0, checks = 0;
  int credit_mode, rst_at;
  int first_tx, last_hs, s_first_act, s_last_act, s_act_cnt, r_last_act, last_wr;
  int rx_acc, rx_refused, tx_cnt, memen_cnt;
  bit overflow, timed_out, bad_we;
  logic rst_snap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_key;
  endfunction

  // Expected word address sequence: segment 1 then segment 2, aligned, +4 modulo 2^32.
  task automatic build_exp(input logic [31:0] s1, a1, s2, a2);
    exp_addr_q.delete();
    for (int i = 0; i < int'(s1); i++) exp_addr_q.push_back((a1 & 32'hFFFF_FFFC) + 32'(4 * i));
    for (int i = 0; i < int'(s2); i++) exp_addr_q.push_back((a2 & 32'hFFFF_FFFC) + 32'(4 * i));
  endtask

  task automatic run(input int max_cyc);
    int          idle = 0, occ = 0, last_start = 0;
    bit          rd_pend = 0, del_now = 0, rx_took = 0, in_rst = 0, rst_done = 0, hs, done = 0;
    logic [31:0] rd_pend_addr = '0;
    rd_addr_q.delete(); flit_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    first_tx = -1; last_hs = -1; s_first_act = -1; s_last_act = -1; s_act_cnt = 0;
    r_last_act = -1; last_wr = -1; rx_acc = 0; rx_refused = 0; tx_cnt = 0; memen_cnt = 0;
    overflow = 0; timed_out = 0; bad_we = 0; rst_snap = 1'b0;
    foreach (starts[i]) if (starts[i].cyc > last_start) last_start = starts[i].cyc;
    for (int k = 0; k < max_cyc && !done; k++) begin
      @(posedge clk_i); #1;
      if (in_rst) begin rst_ni = 1'b1; in_rst = 0; end
      del_now    = rd_pend;
      mem_data_i = rd_pend ? mem_word(rd_pend_addr) : 32'h0;
      rd_pend    = 0;
      if (rx_took) void'(rx_src_q.pop_front());
      start_i = 1'b0;
      foreach (starts[i]) if (starts[i].cyc == k) begin
        start_i = 1'b1; operation_i = starts[i].op;
        size_i = starts[i].s1; address_i = starts[i].a1;
        size_2_i = starts[i].s2; address_2_i = starts[i].a2;
      end
      case (credit_mode)
        0:       credit_i = 1'b1;
        1:       credit_i = (k % 4 == 0) || (k % 4 == 3);
        default: credit_i = 1'($urandom_range(0, 1));
      endcase
      rx_i   = (rx_src_q.size() > 0);
      data_i = rx_i ? rx_src_q[0] : 32'h0;
      if (rst_at >= 0 && !rst_done && flit_q.size() >= rst_at) begin
        rst_ni = 1'b0; #1;
        rst_snap = |{send_active_o, receive_active_o, mem_en_o, mem_we_o, mem_addr_o,
                     mem_data_o, tx_o, data_o, credit_o};
        in_rst = 1; rst_done = 1; occ = 0; del_now = 0;
      end
      @(negedge clk_i);
      if (mem_en_o) begin
        memen_cnt++;
        if (mem_we_o == 4'hF) begin
          wr_addr_q.push_back(mem_addr_o); wr_data_q.push_back(mem_data_o); last_wr = k;
        end else if (mem_we_o == 4'h0) begin
          if (occ + int'(del_now) >= DEPTH) overflow = 1;
          rd_pend = 1; rd_pend_addr = mem_addr_o; rd_addr_q.push_back(mem_addr_o);
        end else bad_we = 1;
      end
      hs = tx_o && credit_i;
      if (tx_o) begin tx_cnt++; if (first_tx < 0) first_tx = k; end
      if (hs) begin flit_q.push_back(data_o); last_hs = k; end
      occ = occ + int'(del_now) - int'(hs);
      rx_took = rx_i && credit_o;
      if (rx_took) rx_acc++;
      if (rx_i && !credit_o && !receive_active_o) rx_refused++;
      if (send_active_o) begin
        if (s_first_act < 0) s_first_act = k;
        s_last_act = k; s_act_cnt++;
      end
      if (receive_active_o) r_last_act = k;
      if (k > last_start && !send_active_o && !receive_active_o && !in_rst) idle++;
      else idle = 0;
      if (idle >= 3) done = 1;
    end
    if (!done) timed_out = 1;
    if (rx_took) void'(rx_src_q.pop_front());
    start_i = 1'b0; rx_i = 1'b0; data_i = '0; credit_i = 1'b0; rst_ni = 1'b1;
    starts.delete();
    $display("txn: reads=%0d flits=%0d writes=%0d rx_accepted=%0d",
             rd_addr_q.size(), flit_q.size(), wr_addr_q.size(), rx_acc);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_ni = 1'b0; rx_i = 1'b1; credit_i = 1'b1;
    repeat (3) @(negedge clk_i);
    v = 32'({send_active_o, receive_active_o, mem_en_o, mem_we_o, tx_o, credit_o})
        | mem_addr_o | mem_data_o | data_o;
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_outputs: got %0h want 0", v); end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (credit_o !== 1'b0) begin errors++; $display("FAIL idle_credit: got %0b want 0", credit_o); end
    checks++; if ({tx_o, mem_en_o, send_active_o, receive_active_o} !== 4'b0) begin
      errors++; $display("FAIL idle_outputs: got %0b want 0", {tx_o, mem_en_o, send_active_o, receive_active_o});
    end
    rx_i = 1'b0; credit_i = 1'b0;
  endtask

  task automatic test_send_basic;
    credit_mode = 0; rst_at = -1;
    starts.push_back('{0, 1'b0, 32'd3, 32'h100, 32'd2, 32'h200});
    build_exp(3, 32'h100, 2, 32'h200);
    run(200);
    checks++; if (timed_out) begin errors++; $display("FAIL send_basic_timeout: got 1 want 0"); end
    checks++; if (rd_addr_q.size() != 5) begin errors++; $display("FAIL send_basic_reads: got %0d want 5", rd_addr_q.size()); end
    for (int i = 0; i < 5 && i < rd_addr_q.size(); i++) begin
      checks++; if (rd_addr_q[i] !== exp_addr_q[i]) begin errors++; $display("FAIL send_basic_addr[%0d]: got %h want %h", i, rd_addr_q[i], exp_addr_q[i]); end
    end
    checks++; if (flit_q.size() != 5) begin errors++; $display("FAIL send_basic_flits: got %0d want 5", flit_q.size()); end
    for (int i = 0; i < 5 && i < flit_q.size(); i++) begin
      checks++; if (flit_q[i] !== mem_word(exp_addr_q[i])) begin errors++; $display("FAIL send_basic_data[%0d]: got %h want %h", i, flit_q[i], mem_word(exp_addr_q[i])); end
    end
    checks++; if (s_last_act != last_hs) begin errors++; $display("FAIL send_basic_fall: got last_active=%0d want %0d", s_last_act, last_hs); end
    checks++; if (s_first_act != 1) begin errors++; $display("FAIL send_basic_rise: got %0d want 1", s_first_act); end
    checks++; if (first_tx < 2) begin errors++; $display("FAIL send_basic_first_tx: got %0d want >=2", first_tx); end
  endtask

  task automatic test_send_credit_toggle;
    credit_mode = 1; rst_at = -1;
    starts.push_back('{0, 1'b0, 32'd3, 32'h100, 32'd2, 32'h200});
    build_exp(3, 32'h100, 2, 32'h200);
    run(300);
    checks++; if (flit_q.size() != 5 || timed_out) begin errors++; $display("FAIL toggle_flits: got %0d want 5", flit_q.size()); end
    for (int i = 0; i < 5 && i < flit_q.size(); i++) begin
      checks++; if (flit_q[i] !== mem_word(exp_addr_q[i])) begin errors++; $display("FAIL toggle_data[%0d]: got %h want %h", i, flit_q[i], mem_word(exp_addr_q[i])); end
    end
    checks++; if (overflow || bad_we) begin errors++; $display("FAIL toggle_overflow: got %0b want 0", overflow | bad_we); end
  endtask

  task automatic test_receive;
    credit_mode = 0; rst_at = -1;
    for (int i = 0; i < 5; i++) rx_src_q.push_back(32'hA0 + 32'(i));
    starts.push_back('{0, 1'b1, 32'd4, 32'h400, 32'd0, 32'h0});
    run(200);
    checks++; if (wr_addr_q.size() != 4 || timed_out) begin errors++; $display("FAIL recv_writes: got %0d want 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'h400 + 32'(4 * i) || wr_data_q[i] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL recv_write[%0d]: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 32'h400 + 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
    checks++; if (rx_acc != 4 || rx_src_q.size() != 1) begin errors++; $display("FAIL recv_fifth_flit: got accepted=%0d left=%0d want 4/1", rx_acc, rx_src_q.size()); end
    checks++; if (r_last_act != last_wr) begin errors++; $display("FAIL recv_fall: got %0d want %0d", r_last_act, last_wr); end
    checks++; if (rx_refused == 0 || rd_addr_q.size() != 0) begin errors++; $display("FAIL recv_idle_refuse: got refused=%0d reads=%0d want >0/0", rx_refused, rd_addr_q.size()); end
    rx_src_q.delete();
  endtask

  task automatic test_concurrent;
    credit_mode = 0; rst_at = -1;
    exp_data_q.delete();
    for (int i = 0; i < 4; i++) begin exp_data_q.push_back($urandom); rx_src_q.push_back(exp_data_q[i]); end
    starts.push_back('{0, 1'b0, 32'd4, 32'h000, 32'd0, 32'h0});
    starts.push_back('{1, 1'b1, 32'd4, 32'h800, 32'd0, 32'h0});
    run(300);
    checks++; if (flit_q.size() != 4 || wr_addr_q.size() != 4 || timed_out) begin
      errors++; $display("FAIL conc_counts: got flits=%0d writes=%0d want 4/4", flit_q.size(), wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < flit_q.size(); i++) begin
      checks++; if (flit_q[i] !== mem_word(32'(4 * i))) begin errors++; $display("FAIL conc_flit[%0d]: got %h want %h", i, flit_q[i], mem_word(32'(4 * i))); end
    end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'h800 + 32'(4 * i) || wr_data_q[i] !== exp_data_q[i]) begin
        errors++; $display("FAIL conc_write[%0d]: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 32'h800 + 32'(4 * i), exp_data_q[i]);
      end
    end
    checks++; if (overflow || bad_we) begin errors++; $display("FAIL conc_overflow: got 1 want 0"); end
    rx_src_q.delete();
  endtask

  task automatic test_zero_and_busy;
    credit_mode = 0; rst_at = -1;
    starts.push_back('{0, 1'b0, 32'd0, 32'h40, 32'd0, 32'h80});
    run(50);
    checks++; if (s_act_cnt != 1 || s_first_act != 1) begin errors++; $display("FAIL zero_active: got cycles=%0d rise=%0d want 1/1", s_act_cnt, s_first_act); end
    checks++; if (tx_cnt != 0 || memen_cnt != 0) begin errors++; $display("FAIL zero_quiet: got tx=%0d mem=%0d want 0/0", tx_cnt, memen_cnt); end
    starts.push_back('{0, 1'b0, 32'd3, 32'h600, 32'd0, 32'h0});
    starts.push_back('{2, 1'b0, 32'd2, 32'h700, 32'd1, 32'h900});
    build_exp(3, 32'h600, 0, 32'h0);
    run(200);
    checks++; if (rd_addr_q.size() != 3 || flit_q.size() != 3) begin errors++; $display("FAIL busy_ignore: got reads=%0d flits=%0d want 3/3", rd_addr_q.size(), flit_q.size()); end
    for (int i = 0; i < 3 && i < flit_q.size() && i < rd_addr_q.size(); i++) begin
      checks++; if (rd_addr_q[i] !== exp_addr_q[i] || flit_q[i] !== mem_word(exp_addr_q[i])) begin
        errors++; $display("FAIL busy_data[%0d]: got %h/%h want %h/%h", i, rd_addr_q[i], flit_q[i], exp_addr_q[i], mem_word(exp_addr_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid;
    credit_mode = 0; rst_at = 2;
    starts.push_back('{0, 1'b0, 32'd6, 32'h300, 32'd0, 32'h0});
    run(200);
    checks++; if (rst_snap !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got %0b want 0", rst_snap); end
    checks++; if (flit_q.size() != 2 || wr_addr_q.size() != 0) begin errors++; $display("FAIL midrst_flits: got %0d want 2", flit_q.size()); end
    rst_at = -1;
    starts.push_back('{0, 1'b0, 32'd2, 32'h503, 32'd1, 32'h60A});
    build_exp(2, 32'h503, 1, 32'h60A);
    run(200);
    checks++; if (rd_addr_q.size() != 3 || flit_q.size() != 3) begin errors++; $display("FAIL post_rst_counts: got reads=%0d flits=%0d want 3/3", rd_addr_q.size(), flit_q.size()); end
    for (int i = 0; i < 3 && i < flit_q.size() && i < rd_addr_q.size(); i++) begin
      checks++; if (rd_addr_q[i] !== exp_addr_q[i] || flit_q[i] !== mem_word(exp_addr_q[i])) begin
        errors++; $display("FAIL post_rst_data[%0d]: got %h/%h want %h/%h", i, rd_addr_q[i], flit_q[i], exp_addr_q[i], mem_word(exp_addr_q[i]));
      end
    end
  endtask

  task automatic test_random;
    bit op; logic [31:0] s1, s2, a1, a2; int total;
    credit_mode = 2; rst_at = -1;
    for (int t = 0; t < 8; t++) begin
      op = 1'($urandom_range(0, 1)); s1 = $urandom_range(0, 5); s2 = $urandom_range(0, 5);
      a1 = $urandom; a2 = $urandom; total = int'(s1) + int'(s2);
      build_exp(s1, a1, s2, a2);
      exp_data_q.delete();
      if (op) for (int i = 0; i <= total; i++) begin exp_data_q.push_back($urandom); rx_src_q.push_back(exp_data_q[i]); end
      starts.push_back('{0, op, s1, a1, s2, a2});
      run(400);
      if (!op) begin
        checks++; if (flit_q.size() != total || rd_addr_q.size() != total || timed_out || overflow) begin
          errors++; $display("FAIL rand_send_count[%0d]: got flits=%0d reads=%0d want %0d", t, flit_q.size(), rd_addr_q.size(), total);
        end
        for (int i = 0; i < total && i < flit_q.size() && i < rd_addr_q.size(); i++) begin
          checks++; if (rd_addr_q[i] !== exp_addr_q[i] || flit_q[i] !== mem_word(exp_addr_q[i])) begin
            errors++; $display("FAIL rand_send_data[%0d.%0d]: got %h/%h want %h/%h", t, i, rd_addr_q[i], flit_q[i], exp_addr_q[i], mem_word(exp_addr_q[i]));
          end
        end
        checks++; if ((total > 0) ? (s_last_act != last_hs) : (s_act_cnt != 1)) begin
          errors++; $display("FAIL rand_send_fall[%0d]: got last_active=%0d cycles=%0d want hs=%0d", t, s_last_act, s_act_cnt, last_hs);
        end
      end else begin
        checks++; if (wr_addr_q.size() != total || rx_acc != total || timed_out) begin
          errors++; $display("FAIL rand_recv_count[%0d]: got writes=%0d accepted=%0d want %0d", t, wr_addr_q.size(), rx_acc, total);
        end
        for (int i = 0; i < total && i < wr_addr_q.size(); i++) begin
          checks++; if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
            errors++; $display("FAIL rand_recv_data[%0d.%0d]: got %h/%h want %h/%h", t, i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
          end
        end
      end
      rx_src_q.delete();
    end
  endtask

  initial begin
    mem_key = $urandom;
    test_reset;
    test_send_basic;
    test_send_credit_toggle;
    test_receive;
    test_concurrent;
    test_zero_and_busy;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
